// File: rtl/axi_rd_slave.sv
// axi_rd_slave: AXI4 read-channel slave returning 16-bit RAM words one beat at a time
//   a_clk/a_rst_n            clock, async active-low reset
//   arvalid/arready/araddr/arlen/arsize/arburst   read address channel
//   rvalid/rready/rdata/rresp/rlast               read data channel
//   a_address_rd/a_rd/a_data_in                   RAM read port (data valid cycle after a_rd)
module axi_rd_slave #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int RAM_ADDR_W = 13,
  parameter int RAM_DATA_W = 16
) (
  input  logic                  a_clk,
  input  logic                  a_rst_n,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [AXI_ADDR_W-1:0] araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [AXI_DATA_W-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic [RAM_ADDR_W-1:0] a_address_rd,
  output logic                  a_rd,
  input  logic [RAM_DATA_W-1:0] a_data_in
);
  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_CAP, R_OUT} state_t;
  state_t r_state;
  logic [RAM_ADDR_W-1:0] r_addr, r_address_rd;
  logic [AXI_DATA_W-1:0] r_rdata;
  logic [3:0] r_beats;
  logic [1:0] r_rresp;
  logic r_incr, r_err, r_arready, r_rvalid, r_rlast, r_a_rd;
  logic w_err, w_unused;
  logic [RAM_ADDR_W-1:0] w_araddr, w_next_addr;
  logic [RAM_DATA_W-1:0] w_word;
  // byte address -> word address; the top address bits and byte lane bit are ignored
  assign w_araddr = araddr[RAM_ADDR_W:1];
  assign w_unused = ^{araddr[AXI_ADDR_W-1:RAM_ADDR_W+1], araddr[0]};
  assign w_err = (arsize != 3'b001) || arburst[1];
  // INCR wraps naturally at the RAM_ADDR_W boundary
  assign w_next_addr = r_incr ? r_addr + 1'b1 : r_addr;
  assign w_word = r_err ? {RAM_DATA_W{1'b0}} : a_data_in;
  assign arready = r_arready;
  assign rvalid = r_rvalid;
  assign rdata = r_rdata;
  assign rresp = r_rresp;
  assign rlast = r_rlast;
  assign a_address_rd = r_address_rd;
  assign a_rd = r_a_rd;
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_address_rd <= '0;
      r_rdata <= '0;
      r_beats <= '0;
      r_rresp <= '0;
      r_incr <= 1'b0;
      r_err <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid <= 1'b0;
      r_rlast <= 1'b0;
      r_a_rd <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_arready <= 1'b1;
          if (arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_addr <= w_araddr;
            r_beats <= arlen;
            r_incr <= arburst == 2'b01;
            r_err <= w_err;
            r_a_rd <= !w_err;
            if (!w_err) r_address_rd <= w_araddr;
            r_state <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          r_a_rd <= 1'b0;
          r_state <= RD_CAP;
        end
        RD_CAP: begin
          r_rdata <= {{(AXI_DATA_W-RAM_DATA_W){1'b0}}, w_word};
          r_rresp <= r_err ? 2'b10 : 2'b00;
          r_rlast <= r_beats == 4'd0;
          r_rvalid <= 1'b1;
          r_state <= R_OUT;
        end
        R_OUT: begin
          if (rready) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_arready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_beats <= r_beats - 1'b1;
              r_addr <= w_next_addr;
              r_a_rd <= !r_err;
              // error bursts never touch the RAM port, so its address is left alone
              if (!r_err) r_address_rd <= w_next_addr;
              r_state <= RD_ADDR;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axi_rd_slave.md
# axi_rd_slave

AXI4 read-channel slave for the FIR register/coefficient RAM: accepts AR requests, reads 16-bit words from the RAM read port one beat at a time, and returns them on the R channel.
- Counterpart of the AXI write-path slave.
- Shares the same RAM with it (write port on the write slave, read port here), sharing the same 13-bit word address space and the same byte-to-word mapping.

## Interface
Parameters:
- AXI_ADDR_W, 32, AXI address width
- AXI_DATA_W, 64, AXI data bus width
- RAM_ADDR_W, 13, RAM word address width
- RAM_DATA_W, 16, RAM word width

Ports:
- a_clk  in  1  single clock; all logic on rising edge
- a_rst_n  in  1  reset, asynchronous, active-low
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  AXI_ADDR_W  byte address
- arlen  in  4  beats minus one (1..16 beats)
- arsize  in  3  beat size; only 3'b001 (2 bytes) supported
- arburst  in  2  00 FIXED, 01 INCR supported; 10/11 unsupported
- rvalid  out  1  read data valid
- rready  in  1  master ready for read data
- rdata  out  AXI_DATA_W  {48'b0, word}; RAM word on rdata[15:0]
- rresp  out  2  00 OKAY, 10 SLVERR
- rlast  out  1  final beat of burst
- a_address_rd  out  RAM_ADDR_W  RAM read word address
- a_rd  out  1  RAM read enable
- a_data_in  in  RAM_DATA_W  RAM read data, valid the cycle after a_rd

## Operation
- States: IDLE, RD_ADDR, RD_CAP, R_OUT.
- IDLE: arready=1. On arvalid&&arready:
  - latch addr=araddr[13:1], beats_left=arlen, burst and size.
  - err=(arsize!=3'b001)||(arburst[1]==1).
  - go to RD_ADDR.
- RD_ADDR: a_address_rd=addr; a_rd=!err. Next: RD_CAP.
- RD_CAP: at end of cycle, capture rdata[15:0]=err?16'h0:a_data_in and rdata[63:16]=0. Also set rresp=err?2'b10:2'b00 and rlast=(beats_left==0). Next: R_OUT.
- R_OUT: rvalid=1; rdata/rresp/rlast held stable until rvalid&&rready.
  - On handshake with rlast=1: go to IDLE.
  - On handshake otherwise: beats_left-1; addr+1 if INCR, unchanged if FIXED; go to RD_ADDR.
- Error bursts still return exactly arlen+1 beats, all SLVERR, data 0, and never pulse a_rd.
- Address: araddr[0] and araddr[31:14] are ignored. INCR wraps modulo 2^13 (13'h1FFF -> 13'h0000).
- arready=0 outside IDLE. No outstanding or overlapping transactions.
- Outputs are driven from registers only; no combinational path from inputs to outputs.

## Timing
- Reset (a_rst_n=0, asynchronous, effective immediately):
  - state=IDLE.
  - arready=0, rvalid=0, rlast=0, rresp=00, rdata=0, a_rd=0, a_address_rd=0.
  - Internal counters cleared.
  - arready rises at the first a_clk edge after reset release.
- Reset during a burst: the burst is discarded silently; no further beats.
- AR handshake at edge N:
  - RD_ADDR during cycle N+1 (a_rd high for exactly 1 cycle).
  - RD_CAP during N+2.
  - rvalid high from N+3.
- First-beat latency: 3 cycles after the AR handshake edge.
- Minimum throughput: 1 beat per 3 cycles with rready held high.
- rvalid stalls indefinitely while rready=0. No timeout.
- After the last-beat handshake at edge M: rvalid=0 and arready=1 during cycle M+1. The next AR can be accepted at edge M+1.
- arvalid while busy: ignored until IDLE; arvalid must be held by the master.
- rready high outside R_OUT: no effect.
- a_address_rd holds its last value when a_rd=0.

## Test plan
- Single INCR read:
  - Stimulus: preload word 5 = 16'hABCD; araddr=32'h0A, arlen=0, arsize=001, arburst=01.
  - Required: a_rd one cycle with a_address_rd=5; 3 cycles later rvalid=1, rdata=64'h000000000000ABCD, rresp=00, rlast=1; arready=1 the cycle after the handshake.
- 4-beat INCR with rready toggling:
  - Stimulus: words 0x10..0x13 = 16'h1111/2222/3333/4444; araddr=32'h20, arlen=3; rready low for 2 cycles on beat 2.
  - Required: data returned in order; beat 2 held stable while stalled; rlast only on beat 4.
- FIXED burst:
  - Stimulus: araddr=32'h0A, arlen=2, arburst=00.
  - Required: three beats of word 5; a_address_rd=5 on every read.
- Error burst:
  - Stimulus: arsize=010 or arburst=10, arlen=1.
  - Required: two beats, rresp=10, rdata=0, rlast on second beat; a_rd never asserted.
- Wrap-around:
  - Stimulus: araddr=32'h3FFE, arlen=1, INCR.
  - Required: reads word 13'h1FFF then 13'h0000.
- Reset mid-burst:
  - Stimulus: assert a_rst_n=0 while rvalid=1 on beat 2 of 4.
  - Required: rvalid, rlast and arready drop immediately; after release, arready=1 at the first edge and a new single read completes normally.
